// File: rtl/output_port_arbiter.sv
// Wormhole output-port arbiter: round-robin on head flits, locks the port to the
// winning packet until its tail, and honours per-VC on/off downstream flow control.
module output_port_arbiter #(
  parameter int PORT_NUM    = 5,
  parameter int VC_NUM      = 2,
  parameter int MAX_PKT_LEN = 16,
  localparam int PORT_SIZE  = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1,
  localparam int VC_SIZE    = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORT_NUM-1:0]         req_i,
  input  logic [PORT_NUM-1:0]         head_i,
  input  logic [PORT_NUM-1:0]         tail_i,
  input  logic [PORT_NUM*VC_SIZE-1:0] vc_i,
  input  logic [VC_NUM-1:0]           on_off_i,
  output logic [PORT_NUM-1:0]         grant_o,
  output logic [PORT_SIZE-1:0]        sel_o,
  output logic                        valid_flit_o,
  output logic [VC_SIZE-1:0]          vc_o,
  output logic                        locked_o,
  output logic                        error_o
);

  localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);
  localparam logic [CNT_W-1:0]     MAX_LEN = CNT_W'(MAX_PKT_LEN);
  localparam logic [PORT_SIZE:0]   PN_EXT  = (PORT_SIZE + 1)'(PORT_NUM);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [PORT_SIZE-1:0]  rr_q, rr_d;
  logic [PORT_SIZE-1:0]  owner_q, owner_d;
  logic [VC_SIZE-1:0]    lock_vc_q, lock_vc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  valid_q;
  logic [VC_SIZE-1:0]    vc_q;
  logic                  error_q, error_d;

  logic [VC_SIZE-1:0]    vc_arr [PORT_NUM];
  logic [PORT_NUM-1:0]   eligible;
  logic [PORT_NUM-1:0]   cand;
  logic                  rr_found;
  logic [PORT_SIZE-1:0]  rr_win;
  logic [PORT_SIZE-1:0]  rr_next;
  logic                  granted;
  logic [PORT_SIZE-1:0]  win;
  logic [VC_SIZE-1:0]    win_vc;
  logic [CNT_W-1:0]      cnt_inc;

  // Per-port VC and eligibility: a port counts only if its target VC is on.
  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) begin
      vc_arr[p]   = vc_i[p*VC_SIZE +: VC_SIZE];
      eligible[p] = req_i[p] & on_off_i[vc_arr[p]];
    end
    cand = eligible & head_i;
  end

  // Round-robin search starting at rr_q, wrapping at PORT_NUM.
  always_comb begin
    logic [PORT_SIZE:0] idx;
    rr_found = 1'b0;
    rr_win   = '0;
    idx      = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      idx = {1'b0, rr_q} + (PORT_SIZE + 1)'(i);
      if (idx >= PN_EXT) idx = idx - PN_EXT;
      if (!rr_found && cand[idx[PORT_SIZE-1:0]]) begin
        rr_found = 1'b1;
        rr_win   = idx[PORT_SIZE-1:0];
      end
    end
  end

  always_comb begin
    logic [PORT_SIZE:0] nxt;
    nxt = {1'b0, rr_win} + (PORT_SIZE + 1)'(1);
    if (nxt == PN_EXT) nxt = '0;
    rr_next = nxt[PORT_SIZE-1:0];
  end

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    lock_vc_d = lock_vc_q;
    cnt_d     = cnt_q;
    error_d   = 1'b0;
    granted   = 1'b0;
    win       = '0;
    case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          granted = 1'b1;
          win     = rr_win;
          rr_d    = rr_next;
          if (!tail_i[rr_win]) begin
            if (CNT_W'(1) == MAX_LEN) begin
              error_d = 1'b1;
            end else begin
              state_d   = S_LOCKED;
              owner_d   = rr_win;
              lock_vc_d = vc_arr[rr_win];
              cnt_d     = CNT_W'(1);
            end
          end
        end
      end
      S_LOCKED: begin
        // A fresh head from the owner mid-packet means the packet was cut short upstream.
        if (req_i[owner_q] && head_i[owner_q]) begin
          error_d = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (req_i[owner_q] && on_off_i[lock_vc_q]) begin
          granted = 1'b1;
          win     = owner_q;
          if (tail_i[owner_q]) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_inc == MAX_LEN) begin
            error_d = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign win_vc = vc_arr[win];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      owner_q   <= '0;
      lock_vc_q <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      vc_q      <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      lock_vc_q <= lock_vc_d;
      cnt_q     <= cnt_d;
      valid_q   <= granted;
      error_q   <= error_d;
      if (granted) vc_q <= win_vc;
    end
  end

  always_comb begin
    grant_o = '0;
    sel_o   = '0;
    if (rst && granted) begin
      grant_o[win] = 1'b1;
      sel_o        = win;
    end
  end

  assign valid_flit_o = valid_q;
  assign vc_o         = vc_q;
  assign locked_o     = (state_q == S_LOCKED);
  assign error_o      = error_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: directed scenarios plus random traffic, checked
// against a packet-level reference model through expected-value queues.
module tb_output_port_arbiter;

  localparam int PN   = 5;
  localparam int VN   = 2;
  localparam int VW   = 1;
  localparam int PS   = 3;
  localparam int MAXL = 4;
  localparam int EW   = PN + PS + 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [PN-1:0]   req_i = '0;
  logic [PN-1:0]   head_i = '0;
  logic [PN-1:0]   tail_i = '0;
  logic [PN*VW-1:0] vc_i = '0;
  logic [VN-1:0]   on_off_i = '1;
  logic [PN-1:0]   grant_o;
  logic [PS-1:0]   sel_o;
  logic            valid_flit_o;
  logic [VW-1:0]   vc_o;
  logic            locked_o;
  logic            error_o;

  output_port_arbiter #(.PORT_NUM(PN), .VC_NUM(VN), .MAX_PKT_LEN(MAXL)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .head_i(head_i), .tail_i(tail_i),
    .vc_i(vc_i), .on_off_i(on_off_i), .grant_o(grant_o), .sel_o(sel_o),
    .valid_flit_o(valid_flit_o), .vc_o(vc_o), .locked_o(locked_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  // Expected per-cycle word: {grant, sel, locked, valid, error}; VCs of granted flits in order.
  logic [EW-1:0] exp_q[$];
  logic [VW-1:0] flit_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: packet-level view of the port.
  bit m_locked;
  int m_owner, m_lock_vc, m_cnt, m_rr;
  bit m_prev_valid, m_prev_error;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int vc_of(input int p);
    return int'(vc_i[p*VW +: VW]);
  endfunction

  task automatic model_step();
    int win;
    bit err;
    logic [PN-1:0] g;
    logic [PS-1:0] s;
    if (!rst) begin
      m_locked = 0; m_owner = 0; m_lock_vc = 0; m_cnt = 0; m_rr = 0;
      m_prev_valid = 0; m_prev_error = 0;
      flit_q.delete();
      exp_q.push_back('0);
      return;
    end
    win = -1;
    err = 0;
    if (!m_locked) begin
      for (int i = 0; i < PN; i++) begin
        int p;
        p = (m_rr + i) % PN;
        if (win < 0 && req_i[p] && head_i[p] && on_off_i[vc_of(p)]) win = p;
      end
    end else if (req_i[m_owner] && head_i[m_owner]) begin
      err = 1;
    end else if (req_i[m_owner] && on_off_i[m_lock_vc]) begin
      win = m_owner;
    end
    g = '0;
    s = '0;
    if (win >= 0) begin
      g[win] = 1'b1;
      s = PS'(win);
      flit_q.push_back(VW'(vc_of(win)));
    end
    exp_q.push_back({g, s, m_locked, m_prev_valid, m_prev_error});
    if (!m_locked) begin
      if (win >= 0) begin
        m_rr = (win + 1) % PN;
        if (!tail_i[win]) begin
          if (MAXL == 1) err = 1;
          else begin
            m_locked = 1; m_owner = win; m_lock_vc = vc_of(win); m_cnt = 1;
          end
        end
      end
    end else if (err) begin
      m_locked = 0; m_cnt = 0;
    end else if (win >= 0) begin
      if (tail_i[win]) begin
        m_locked = 0; m_cnt = 0;
      end else if (m_cnt + 1 == MAXL) begin
        err = 1; m_locked = 0; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    m_prev_valid = (win >= 0);
    m_prev_error = err;
  endtask

  task automatic drive(input logic r_n, input logic [PN-1:0] rq, input logic [PN-1:0] hd,
                       input logic [PN-1:0] tl, input logic [PN*VW-1:0] vc, input logic [VN-1:0] oo);
    @(posedge clk);
    #1;
    rst = r_n; req_i = rq; head_i = hd; tail_i = tl; vc_i = vc; on_off_i = oo;
    model_step();
  endtask

  // Monitor: compares every cycle's outputs and each presented flit's VC.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("grant", 32'(grant_o), 32'(e[EW-1 -: PN]));
      check("sel", 32'(sel_o), 32'(e[PS+2:3]));
      check("locked", 32'(locked_o), 32'(e[2]));
      check("valid", 32'(valid_flit_o), 32'(e[1]));
      check("error", 32'(error_o), 32'(e[0]));
    end
    if (valid_flit_o) begin
      if (flit_q.size() == 0) check("flit_q_underflow", 32'(1), 32'(0));
      else check("vc_o", 32'(vc_o), 32'(flit_q.pop_front()));
    end
  end

  initial begin
    // 1: reset with all heads requesting, then port 0 wins from rr_ptr=0
    drive(0, 5'b11111, 5'b11111, 5'b11111, 5'b00000, 2'b11);
    drive(0, 5'b11111, 5'b11111, 5'b11111, 5'b00000, 2'b11);
    drive(1, 5'b11111, 5'b11111, 5'b11111, 5'b00000, 2'b11);
    drive(1, 5'b11111, 5'b11111, 5'b11111, 5'b10100, 2'b11);
    // 2: ports 1 and 3 single-flit packets every cycle
    drive(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b11);
    for (int i = 0; i < 6; i++)
      drive(1, 5'b01010, 5'b01010, 5'b01010, PN'($urandom_range(0, 31)), 2'b11);
    // 3: port 2 four-flit packet on vc 1, port 0 heads throughout
    drive(1, 5'b00100, 5'b00100, 5'b00000, 5'b00100, 2'b11);
    drive(1, 5'b00101, 5'b00001, 5'b00001, 5'b00100, 2'b11);
    drive(1, 5'b00101, 5'b00001, 5'b00001, 5'b00100, 2'b11);
    drive(1, 5'b00101, 5'b00001, 5'b00101, 5'b00100, 2'b11);
    drive(1, 5'b00001, 5'b00001, 5'b00001, 5'b00000, 2'b11);
    // 4: vc 1 turned off mid-packet, port 4 head on vc 0 ignored
    drive(1, 5'b00100, 5'b00100, 5'b00000, 5'b00100, 2'b11);
    drive(1, 5'b00100, 5'b00000, 5'b00000, 5'b00100, 2'b11);
    for (int i = 0; i < 3; i++)
      drive(1, 5'b10100, 5'b10000, 5'b10000, 5'b00100, 2'b01);
    drive(1, 5'b10100, 5'b10000, 5'b10000, 5'b00100, 2'b11);
    drive(1, 5'b10100, 5'b10000, 5'b10100, 5'b00100, 2'b11);
    drive(1, 5'b10000, 5'b10000, 5'b10000, 5'b00000, 2'b11);
    // 5: watchdog, port 1 sends six non-tail flits
    drive(1, 5'b00010, 5'b00010, 5'b00000, 5'b00010, 2'b11);
    for (int i = 0; i < 5; i++)
      drive(1, 5'b00010, 5'b00000, 5'b00000, 5'b00010, 2'b11);
    // 6: owner sends a second head while locked
    drive(1, 5'b01000, 5'b01000, 5'b00000, 5'b00000, 2'b11);
    drive(1, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 2'b11);
    drive(1, 5'b01000, 5'b01000, 5'b00000, 5'b00000, 2'b11);
    drive(1, 5'b01000, 5'b01000, 5'b00000, 5'b00000, 2'b11);
    drive(1, 5'b01000, 5'b00000, 5'b01000, 5'b00000, 2'b11);
    // reset mid-packet, then arbitration restarts from port 0
    drive(1, 5'b00100, 5'b00100, 5'b00000, 5'b00000, 2'b11);
    drive(1, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 2'b11);
    drive(0, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 2'b11);
    drive(1, 5'b10001, 5'b10001, 5'b10001, 5'b00000, 2'b11);
    drive(1, 5'b10001, 5'b10001, 5'b10001, 5'b00000, 2'b11);
    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      logic [PN-1:0] rq, hd, tl;
      logic [VN-1:0] oo;
      for (int p = 0; p < PN; p++) begin
        rq[p] = ($urandom_range(0, 3) != 0);
        hd[p] = ($urandom_range(0, 4) == 0);
        tl[p] = ($urandom_range(0, 3) == 0);
      end
      for (int v = 0; v < VN; v++) oo[v] = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 99) != 0), rq, hd, tl, PN'($urandom_range(0, 31)), oo);
    end
    drive(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b11);
    drive(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b11);
    @(negedge clk);
    #1;
    check("flit_q_drained", 32'(flit_q.size()), 32'(0));
    check("exp_q_drained", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
